// File: rtl/lfsr.sv
// lfsr: parameterised Fibonacci linear-feedback shift register.
// The register shifts left with the feedback bit entering at bit 0.
// An all-zero state (only reachable through a zero SEED) is escaped on the
// next enabled clock. The output comes straight from the state flops.
module lfsr #(
    parameter int unsigned WIDTH = 10,
    parameter logic [31:0] SEED  = 32'h0000_0001,
    parameter logic [31:0] TAPS  = 32'h0000_0240
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] out
);

    // Only the low WIDTH bits of the seed and tap mask are meaningful.
    localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] TAPS_W = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Value loaded when leaving the all-zero lock-up state. A zero seed
    // would leave the register stuck, so fall back to 1 in that case.
    localparam logic [WIDTH-1:0] RECOVER_W = (SEED_W == ZERO_W) ? ONE_W : SEED_W;

    // Feedback bit: parity of the tapped state bits.
    function automatic logic feedback_f(input logic [WIDTH-1:0] s);
        return ^(s & TAPS_W);
    endfunction

    // Power-up value in simulation is the seed. Hardware holds an
    // unspecified value until the first reset edge.
    logic [WIDTH-1:0] state_q = SEED_W;
    logic [WIDTH-1:0] state_d;

    // Next-state selection: hold, lock-up recovery, or one shift step.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = state_q;
        end else if (state_q == ZERO_W) begin
            state_d = RECOVER_W;
        end else begin
            state_d = {state_q[WIDTH-2:0], feedback_f(state_q)};
        end
    end

    // State register. Reset is synchronous and overrides the enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED_W;
        end else begin
            state_q <= state_d;
        end
    end

    assign out = state_q;

endmodule

// File: tb/tb_lfsr.sv
// tb_lfsr: self-checking bench for lfsr. Three instances share clock, reset
// and enable: the default configuration, a zero-seed configuration, and a
// 4-bit configuration. Each is tracked by an arithmetic reference model.
module tb_lfsr;

    logic       clk;
    logic       rst;
    logic       en;
    logic [9:0] out_a;
    logic [9:0] out_z;
    logic [3:0] out_s;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state for each instance, kept as plain integers.
    logic [31:0] m_a = 32'd1;
    logic [31:0] m_z = 32'd0;
    logic [31:0] m_s = 32'd1;

    lfsr u_dflt (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .out (out_a)
    );

    lfsr #(
        .WIDTH (10),
        .SEED  (32'h0000_0000),
        .TAPS  (32'h0000_0240)
    ) u_zero (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .out (out_z)
    );

    lfsr #(
        .WIDTH (4),
        .SEED  (32'h0000_0001),
        .TAPS  (32'h0000_000C)
    ) u_small (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .out (out_s)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural next-state rule: reset loads the seed; disabled holds;
    // zero escapes to the seed (or 1); otherwise double modulo 2^w and add
    // the parity of the tapped bits.
    function automatic logic [31:0] model_next(input logic [31:0] s, input int w,
                                               input logic [31:0] taps, input logic [31:0] seed,
                                               input logic r, input logic e);
        logic [31:0] modulus;
        logic [31:0] sd;
        modulus = 32'd1 << w;
        sd      = seed % modulus;
        if (r) return sd;
        if (!e) return s;
        if (s == 32'd0) return (sd == 32'd0) ? 32'd1 : sd;
        return ((s * 32'd2) % modulus) + ($countones(s & taps) % 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one clock with the given controls, advance models, compare all.
    task automatic tick(input logic r, input logic e);
        rst = r;
        en  = e;
        @(posedge clk);
        #1;
        m_a = model_next(m_a, 10, 32'h240, 32'h1, r, e);
        m_z = model_next(m_z, 10, 32'h240, 32'h0, r, e);
        m_s = model_next(m_s, 4,  32'hC,   32'h1, r, e);
        check("step_dflt",  {22'd0, out_a}, m_a);
        check("step_zero",  {22'd0, out_z}, m_z);
        check("step_small", {28'd0, out_s}, m_s);
    endtask

    logic [9:0] seq21 [0:10];
    logic       seen  [0:1023];

    initial begin
        int zero_a;
        int dup_a;
        int distinct_a;
        int early_a;
        int period_s;
        int zero_s;

        seq21 = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h010, 10'h020,
                  10'h040, 10'h081, 10'h102, 10'h204, 10'h009};
        rst = 1'b0;
        en  = 1'b0;

        // Power-up simulation value equals the seed.
        #1;
        check("powerup_dflt",  {22'd0, out_a}, 32'h001);
        check("powerup_zero",  {22'd0, out_z}, 32'h000);
        check("powerup_small", {28'd0, out_s}, 32'h1);

        // Reset state, held over several cycles.
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0);
            check("reset_hold", {22'd0, out_a}, 32'h001);
        end
        check("reset_zero_seed", {22'd0, out_z}, 32'h000);

        // Ten enabled clocks from reset follow the known sequence.
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0, 1'b1);
            check("seq10", {22'd0, out_a}, {22'd0, seq21[i]});
            if (i == 1) check("zero_recover", {22'd0, out_z}, 32'h001);
            if (i == 2) check("zero_step2",   {22'd0, out_z}, 32'h002);
        end

        // Hold with enable low.
        tick(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        check("pre_hold", {22'd0, out_a}, 32'h008);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0);
            check("hold", {22'd0, out_a}, 32'h008);
        end
        tick(1'b0, 1'b1);
        check("after_hold", {22'd0, out_a}, 32'h010);

        // Reset mid-sequence with enable also high.
        tick(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b1);
        check("pre_midreset", {22'd0, out_a}, 32'h081);
        tick(1'b1, 1'b1);
        check("rst_over_en", {22'd0, out_a}, 32'h001);
        tick(1'b0, 1'b1);
        check("after_midreset", {22'd0, out_a}, 32'h002);

        // Full period walk for the default and 4-bit instances.
        tick(1'b1, 1'b0);
        for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
        zero_a = 0; dup_a = 0; distinct_a = 0; early_a = 0;
        period_s = 0; zero_s = 0;
        for (int i = 1; i <= 1023; i++) begin
            tick(1'b0, 1'b1);
            if (out_a == 10'd0) zero_a++;
            if (seen[out_a]) dup_a++;
            else distinct_a++;
            seen[out_a] = 1'b1;
            if (i < 1023 && out_a == 10'h001) early_a++;
            if (out_s == 4'd0) zero_s++;
            if (period_s == 0 && out_s == 4'h1) period_s = i;
        end
        check("period_end",      {22'd0, out_a}, 32'h001);
        check("period_zero",     zero_a,     32'd0);
        check("period_dup",      dup_a,      32'd0);
        check("period_distinct", distinct_a, 32'd1023);
        check("period_early",    early_a,    32'd0);
        check("small_period",    period_s,   32'd15);
        check("small_zero",      zero_s,     32'd0);

        // Randomised enable and occasional reset.
        for (int i = 0; i < 2000; i++) begin
            tick(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lfsr.md
LFSR -- requirements
Module: lfsr

Interface
REQ-001 SHALL provide parameter WIDTH, default 10, register and output width in bits.
REQ-002 SHALL provide parameter SEED, default 10'h001, reset and lock-up recovery value; only the low WIDTH bits are used.
REQ-003 SHALL provide parameter TAPS, default 10'h240, feedback tap mask (bit i set = state bit i feeds the XOR); the default selects bits 9 and 6, polynomial x^10+x^7+1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port en, input, 1 bit: advance enable.
REQ-007 SHALL have port out, output, WIDTH bits: current register state, driven directly from the state flops with no combinational path from any input.

Function
REQ-008 SHALL be a Fibonacci LFSR: feedback bit fb = XOR-reduction of (state AND TAPS).
REQ-009 SHALL, on a rising edge with rst=0 and en=1, load next state = {state[WIDTH-2:0], fb}, i.e. shift left with fb entering at bit 0.
REQ-010 SHALL hold state unchanged on a rising edge with rst=0 and en=0.
REQ-011 SHALL make out change only on rising clk edges; the one-cycle update latency applies: the new value is visible immediately after the edge.
REQ-012 SHALL, with default parameters, produce a maximal-length sequence of period 1023 that never contains 0.
REQ-013 SHALL detect the all-zero state; when state==0 and en=1 with rst=0, the next state is SEED, or 1 if SEED is 0. This is the lock-up recovery rule.
REQ-014 SHALL, when SEED is 0, start from 0 after reset and recover to 1 on the first enabled clock.
REQ-015 SHALL give rst priority over en when both are asserted on the same edge.
REQ-016 SHALL have out hold an unspecified value between power-up and the first reset edge; simulation initial value is SEED.
REQ-017 SHALL contain no latches, no asynchronous logic and no combinational loops.

Reset
REQ-018 SHALL, on a rising edge with rst=1, load state = SEED regardless of en; the default gives out = 10'h001 after that edge.
REQ-019 SHALL behave identically for reset asserted mid-sequence: the sequence restarts from SEED, and the first enabled clock after rst deasserts produces the step-1 value.
REQ-020 SHALL keep out at SEED while rst stays high for multiple cycles.

Verification
REQ-021 Reset, then 10 enabled clocks (defaults) -> out sequence 001, 002, 004, 008, 010, 020, 040, 081, 102, 204, 009 (hex; first value after reset).
REQ-022 Reset, 3 enabled clocks (out=008), en=0 for 5 clocks -> out stays 008; en=1 for 1 clock -> 010.
REQ-023 Reset, then 1023 enabled clocks -> out returns to 001 exactly at clock 1023, never 0, and all 1023 nonzero values seen once each.
REQ-024 Reset, 7 enabled clocks (out=081), then rst=1 and en=1 on the same edge -> out=001; next enabled clock -> 002.
REQ-025 Instance with SEED=0: reset -> out=000; first enabled clock -> 001; the following clock -> 002.
REQ-026 Instance with WIDTH=4, TAPS=4'hC, SEED=4'h1: reset, then 15 enabled clocks -> period 15, never 0.
